// File: rtl/car_cmd_encoder.sv
// rtl/car_cmd_encoder.sv - debounced left/right/hazard keys to latched tail-light command code
// Optional turn auto-cancel timer: define CAR_CMD_AUTOCANCEL_EN.
module car_cmd_encoder #(
   parameter int CLK_HZ          = 12000000,
   parameter int DEBOUNCE_CYCLES = 240000,
   parameter int TURN_TIMEOUT_S  = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       key_hazard,
   output logic [3:0] sw_code,
   output logic       cmd_valid
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [3:0] CODE_STRAIGHT = 4'b0110;
   localparam logic [3:0] CODE_LEFT     = 4'b1000;
   localparam logic [3:0] CODE_RIGHT    = 4'b0001;
   localparam logic [3:0] CODE_HAZARD   = 4'b1111;

   typedef enum logic [1:0] {ST_STRAIGHT, ST_LEFT, ST_RIGHT, ST_HAZARD} state_t;

   if (DEBOUNCE_CYCLES < 2 || TURN_TIMEOUT_S < 1 || CLK_HZ < 1) begin : g_param_check
      $error("car_cmd_encoder: parameter out of range");
   end

   // Bit order for all key vectors: [0]=left, [1]=right, [2]=hazard.
   logic [2:0]    key_raw;
   logic [2:0]    sync1;
   logic [2:0]    sync2;
   logic [2:0]    deb;
   logic [2:0]    press;
   logic [DW-1:0] db_cnt [3];

   assign key_raw = {key_hazard, key_right, key_left};

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '1;
         sync2 <= '1;
         deb   <= '1;
         press <= '0;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= key_raw;
         sync2 <= sync1;
         for (int i = 0; i < 3; i++) begin
            press[i] <= 1'b0;
            if (sync2[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES)) begin
               // Accept the new level; only a falling (pressed) edge yields a press pulse.
               deb[i]    <= sync2[i];
               db_cnt[i] <= '0;
               press[i]  <= ~sync2[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + DW'(1);
            end
         end
      end
   end

   state_t state;
   state_t state_nxt;
   logic   timeout;
   logic   lone_left;
   logic   lone_right;

   assign lone_left  = press[0] & ~press[1];
   assign lone_right = press[1] & ~press[0];

   always_comb begin
      state_nxt = state;
      case (state)
         ST_STRAIGHT: begin
            if (press[2])        state_nxt = ST_HAZARD;
            else if (lone_left)  state_nxt = ST_LEFT;
            else if (lone_right) state_nxt = ST_RIGHT;
         end
         ST_LEFT: begin
            if (press[2])        state_nxt = ST_HAZARD;
            else if (lone_left)  state_nxt = ST_STRAIGHT;
            else if (lone_right) state_nxt = ST_RIGHT;
            else if (timeout)    state_nxt = ST_STRAIGHT;
         end
         ST_RIGHT: begin
            if (press[2])        state_nxt = ST_HAZARD;
            else if (lone_right) state_nxt = ST_STRAIGHT;
            else if (lone_left)  state_nxt = ST_LEFT;
            else if (timeout)    state_nxt = ST_STRAIGHT;
         end
         ST_HAZARD: begin
            if (press[2])        state_nxt = ST_STRAIGHT;
         end
      endcase
   end

`ifdef CAR_CMD_AUTOCANCEL_EN
   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int SW = $clog2(TURN_TIMEOUT_S + 1);

   logic [PW-1:0] presc;
   logic [SW-1:0] secs;
   logic          tick;
   logic          turn_run;

   assign tick     = (presc == PW'(CLK_HZ - 1));
   // Fire on the tick that would bring the seconds count to the limit, so the
   // cancel edge lands exactly TURN_TIMEOUT_S*CLK_HZ cycles after entry.
   assign timeout  = tick && (secs == SW'(TURN_TIMEOUT_S - 1));
   assign turn_run = (state_nxt == state) && (state == ST_LEFT || state == ST_RIGHT);

   always_ff @(posedge clk) begin
      if (rst || !turn_run) begin
         presc <= '0;
         secs  <= '0;
      end else if (tick) begin
         presc <= '0;
         secs  <= secs + SW'(1);
      end else begin
         presc <= presc + PW'(1);
      end
   end
`else
   assign timeout = 1'b0;
`endif

   function automatic logic [3:0] code_of(input state_t s);
      case (s)
         ST_LEFT:   return CODE_LEFT;
         ST_RIGHT:  return CODE_RIGHT;
         ST_HAZARD: return CODE_HAZARD;
         default:   return CODE_STRAIGHT;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_STRAIGHT;
         sw_code   <= CODE_STRAIGHT;
         cmd_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         sw_code   <= code_of(state_nxt);
         cmd_valid <= (state_nxt != state);
      end
   end

endmodule
